// File: rtl/spi_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ctrl : SPI master controller, one transfer per request.
//
// A host request (valid/ready) carries data, bit count, slave index and bit
// order. The controller asserts one select line, runs N = len+1 sck periods
// (each half-period is div+1 clk cycles), shifts mosi out and miso in, and
// returns the received word on a valid/ready response channel.
//
// Parameters
//   DIV_W      width of the clock-divider input
//   NSS        number of slave-select lines (2-bit select, so NSS <= 4)
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_wdata[31:0]        transmit data
//   req_len[4:0]           bit count minus 1
//   req_ss[1:0]            index of the slave to select
//   req_lsb                1 = LSB first, 0 = MSB first
//   div[DIV_W-1:0]         sck half-period is div+1 clk cycles
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata[31:0]        received data, zero above the bit count
//   busy                   high whenever the controller is not idle
//   sck, ss_n[NSS-1:0]     SPI clock (idles low), active-low selects
//   mosi, miso             SPI data out (idles high) / data in
//   irq                    one-cycle pulse on the first rsp_valid cycle
//                          (present only when SPI_CTRL_IRQ_EN is defined)
//
// Configuration macro: SPI_CTRL_IRQ_EN adds the irq output.
// -----------------------------------------------------------------------------
module spi_ctrl #(
    parameter int DIV_W = 8,
    parameter int NSS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_wdata,
    input  logic [4:0]       req_len,
    input  logic [1:0]       req_ss,
    input  logic             req_lsb,
    input  logic [DIV_W-1:0] div,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             busy,
    output logic             sck,
    output logic [NSS-1:0]   ss_n,
    output logic             mosi,
`ifdef SPI_CTRL_IRQ_EN
    output logic             irq,
`endif
    input  logic             miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_RESP
    } state_t;

    state_t state, state_next;

    // Transfer parameters captured at accept; inputs are ignored afterwards.
    logic [31:0]      wdata_q;
    logic [4:0]       len_q;
    logic [1:0]       ss_q;
    logic             lsb_q;
    logic [DIV_W-1:0] div_q;

    logic [DIV_W-1:0] cnt;      // cycles spent in the current half-period
    logic [4:0]       bit_idx;  // index of the bit currently on the wire
    logic [31:0]      rx;       // receive register, doubles as rsp_rdata

    logic accept;
    logic phase_end;
    logic last_bit;

    // Registered output copies and their next values.
    logic           req_ready_q, busy_q, rsp_valid_q, sck_q, mosi_q;
    logic [NSS-1:0] ss_n_q;
    logic           req_ready_d, busy_d, rsp_valid_d, sck_d, mosi_d;
    logic [NSS-1:0] ss_n_d;
`ifdef SPI_CTRL_IRQ_EN
    logic           irq_q, irq_d;
`endif

    assign accept    = (state == S_IDLE) && req_valid;
    assign phase_end = (cnt == div_q);
    assign last_bit  = (bit_idx == len_q);

    // Bit that goes on the wire in position idx of the transfer.
    function automatic logic tx_bit(input logic [31:0] data, input logic [4:0] len,
                                    input logic lsb, input logic [4:0] idx);
        logic [4:0] pos;
        pos = lsb ? idx : (len - idx);
        return data[pos];
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking (=) here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: assigning a default before the case keeps every path covered,
    // so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (req_valid) state_next = S_SETUP;
            S_SETUP: if (phase_end) state_next = S_HIGH;
            S_HIGH:  if (phase_end) state_next = S_LOW;
            S_LOW:   if (phase_end) state_next = last_bit ? S_RESP : S_HIGH;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: captured request, phase counter, bit index, receive register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q <= '0;
            len_q   <= '0;
            ss_q    <= '0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            rx      <= '0;
        end else begin
            // Counter restarts at every half-period boundary.
            if ((state == S_SETUP || state == S_HIGH || state == S_LOW) && !phase_end)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            if (accept) begin
                wdata_q <= req_wdata;
                len_q   <= req_len;
                ss_q    <= req_ss;
                lsb_q   <= req_lsb;
                div_q   <= div;
                bit_idx <= '0;
                rx      <= '0;   // bits above len stay zero
            end

            // miso is sampled at the end of the high phase, half a period
            // after the slave updated it on the rising edge.
            if (state == S_HIGH && phase_end) begin
                if (lsb_q) rx[bit_idx] <= miso;
                else       rx          <= {rx[30:0], miso};
            end

            if (state == S_LOW && phase_end && !last_bit)
                bit_idx <= bit_idx + 5'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered pins, decoded from the
    // transition so each pin changes on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        logic       active;
        logic [1:0] sel;

        active = (state_next == S_SETUP) || (state_next == S_HIGH) || (state_next == S_LOW);
        sel    = (state == S_IDLE) ? req_ss : ss_q;

        req_ready_d = (state_next == S_IDLE);
        busy_d      = (state_next != S_IDLE);
        rsp_valid_d = (state_next == S_RESP);
        sck_d       = (state_next == S_HIGH);

        for (int i = 0; i < NSS; i++)
            ss_n_d[i] = !(active && (sel == 2'(i)));

        // mosi moves only at SETUP entry and on sck falling; elsewhere it holds.
        mosi_d = mosi_q;
        if (state == S_IDLE && state_next == S_SETUP)
            mosi_d = tx_bit(req_wdata, req_len, req_lsb, 5'd0);
        else if (state == S_HIGH && state_next == S_LOW)
            mosi_d = tx_bit(wdata_q, len_q, lsb_q, bit_idx + 5'd1);
        else if (!active)
            mosi_d = 1'b1;

`ifdef SPI_CTRL_IRQ_EN
        irq_d = (state_next == S_RESP) && (state != S_RESP);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b1;
            ss_n_q      <= '1;
`ifdef SPI_CTRL_IRQ_EN
            irq_q       <= 1'b0;
`endif
        end else begin
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            ss_n_q      <= ss_n_d;
`ifdef SPI_CTRL_IRQ_EN
            irq_q       <= irq_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rx;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign ss_n      = ss_n_q;
`ifdef SPI_CTRL_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule
